// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Constants and types shared by the CPU pipeline control blocks:
//               register-field width, special register numbers, the default
//               mult/div latency and the pipeline-control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int             REG_W              = 5;
  localparam logic [REG_W-1:0] REG_ZERO         = 5'd0;
  localparam logic [REG_W-1:0] REG_RA           = 5'd31;
  localparam int             MULDIV_LATENCY_DEF = 32;

  // One cycle's worth of pipeline enables and squash requests.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // True when a source field names the register an older instruction writes.
  // Register zero is never a real dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of pipeline-stage inputs and sequencing outputs between
//               the datapath (master) and the hazard controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic             ID_HiLoUse;
  logic             ID_EX_MemRead;
  logic [REG_W-1:0] ID_EX_WriteReg;
  logic             EX_MulDivStart;
  logic             PCSrcB;

  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             MulDivBusy;
  logic             MulDivDone;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, ID_HiLoUse,
           ID_EX_MemRead, ID_EX_WriteReg, EX_MulDivStart, PCSrcB,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           MulDivBusy, MulDivDone, StallCycles, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, ID_HiLoUse,
           ID_EX_MemRead, ID_EX_WriteReg, EX_MulDivStart, PCSrcB,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           MulDivBusy, MulDivDone, StallCycles, FlushCount
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_muldiv_tracker.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_tracker
// Description : Tracks occupancy of the HI/LO resource by a multi-cycle
//               mult/div. An 8-bit down-counter is loaded when the operation
//               leaves EX and the unit writes HI/LO in the cycle it reads 1.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_tracker
  import cpu_pkg::*;
#(
  parameter int LATENCY = MULDIV_LATENCY_DEF
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic start_i,
  output logic      busy_o,
  output logic      done_o
);

  localparam logic [7:0] c_LAT = LATENCY[7:0];

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: a start always reloads, even over a running operation, so an
  // aborted operation never produces a done pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = c_LAT;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Busy covers the issue cycle itself so a HI/LO user alongside it stalls.
  assign busy_o = start_i || (cnt_q != 8'd0);
  assign done_o = (cnt_q == 8'd1) && !start_i;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Five-stage pipeline sequencing controller. Stalls on load-use
//               and busy HI/LO, squashes wrong-path fetches on taken branches
//               (EX) and jumps (ID). All enables are combinational.
//               Optional build macro HAZARD_PERF_EN adds saturating stall and
//               flush performance counters; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
  parameter int CNT_W          = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  hazard_ctrl_if.slave  bus
);

  logic  w_load_use;
  logic  w_hilo_stall;
  logic  w_stall;
  logic  w_busy;
  logic  w_done;
  ctrl_t w_ctrl;

  muldiv_tracker #(
    .LATENCY (MULDIV_LATENCY)
  ) u_muldiv_tracker (
    .clk     (clk),
    .reset   (reset),
    .start_i (bus.EX_MulDivStart),
    .busy_o  (w_busy),
    .done_o  (w_done)
  );

  // Hazards that forwarding cannot resolve.
  always_comb begin
    w_load_use   = bus.ID_EX_MemRead &&
                   (reg_dep(bus.ID_Rs, bus.ID_EX_WriteReg) ||
                    (bus.ID_UsesRt && reg_dep(bus.ID_Rt, bus.ID_EX_WriteReg)));
    w_hilo_stall = bus.ID_HiLoUse && w_busy;
    w_stall      = w_load_use || w_hilo_stall;
  end

  // Priority: branch squash beats stall (the stalled instruction is on the
  // wrong path), stall beats jump (the jump stays in ID and retries).
  always_comb begin
    w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1,
               if_id_flush: 1'b0, id_ex_flush: 1'b0};
    if (bus.PCSrcB) begin
      w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1,
                 if_id_flush: 1'b1, id_ex_flush: 1'b1};
    end else if (w_stall) begin
      w_ctrl = '{pc_write: 1'b0, if_id_write: 1'b0,
                 if_id_flush: 1'b0, id_ex_flush: 1'b1};
    end else if (bus.ID_Jump) begin
      w_ctrl = '{pc_write: 1'b1, if_id_write: 1'b1,
                 if_id_flush: 1'b1, id_ex_flush: 1'b0};
    end
  end

  assign bus.PC_Write    = w_ctrl.pc_write;
  assign bus.IF_ID_Write = w_ctrl.if_id_write;
  assign bus.IF_ID_Flush = w_ctrl.if_id_flush;
  assign bus.ID_EX_Flush = w_ctrl.id_ex_flush;
  assign bus.MulDivBusy  = w_busy;
  assign bus.MulDivDone  = w_done;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating increments; a stall hidden under a branch squash is not a
  // real stall and is not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && !bus.PCSrcB && (stall_cnt_q != c_MAX)) begin
      stall_cnt_d = stall_cnt_q + c_ONE;
    end
    if (w_ctrl.if_id_flush && (flush_cnt_q != c_MAX)) begin
      flush_cnt_d = flush_cnt_q + c_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;
`else
  assign bus.StallCycles = '0;
  assign bus.FlushCount  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl (MULDIV_LATENCY=4,
//               CNT_W=4). Vector table for single-cycle hazards plus
//               hand-written mult/div, reset and counter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       hilo;
    logic       memread;
    logic [4:0] wreg;
    logic       mdstart;
    logic       pcsrcb;
  } in_t;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy, MulDivDone}
  typedef logic [5:0] out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  out_t  exp_q[$];
  string name_q[$];

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .MULDIV_LATENCY (LAT),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic uses_rt, input logic jump,
                             input logic hilo, input logic memread,
                             input logic [4:0] wreg, input logic mdstart,
                             input logic pcsrcb);
    in_t r;
    r = '{rs: rs, rt: rt, uses_rt: uses_rt, jump: jump, hilo: hilo,
          memread: memread, wreg: wreg, mdstart: mdstart, pcsrcb: pcsrcb};
    return r;
  endfunction

  task automatic drive(input in_t i);
    bus.ID_Rs          = i.rs;
    bus.ID_Rt          = i.rt;
    bus.ID_UsesRt      = i.uses_rt;
    bus.ID_Jump        = i.jump;
    bus.ID_HiLoUse     = i.hilo;
    bus.ID_EX_MemRead  = i.memread;
    bus.ID_EX_WriteReg = i.wreg;
    bus.EX_MulDivStart = i.mdstart;
    bus.PCSrcB         = i.pcsrcb;
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge,
  // then advance to just past the next rising edge.
  task automatic step(input string name, input in_t i, input out_t e);
    out_t  got;
    out_t  want;
    string nm;
    drive(i);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    got  = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
            bus.MulDivBusy, bus.MulDivDone};
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [CW-1:0] got,
                           input logic [CW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  vec_t tbl[11];
  in_t  idle;
  in_t  lu;

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    lu   = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);

    //                 rs     rt     uRt   jmp   hilo  mrd   wreg   st    br
    tbl[0]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 6'b110000};
    tbl[1]  = '{mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0), 6'b000100};
    tbl[2]  = '{mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0), 6'b110000};
    tbl[3]  = '{mk(5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0), 6'b110000};
    tbl[4]  = '{mk(5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0), 6'b000100};
    tbl[5]  = '{mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1), 6'b111100};
    tbl[6]  = '{mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0), 6'b111000};
    tbl[7]  = '{mk(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0), 6'b000100};
    tbl[8]  = '{mk(5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0), 6'b110000};
    tbl[9]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0), 6'b110000};
    tbl[10] = '{mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), 6'b111100};

    // Reset state with idle inputs.
    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    step("reset_idle", idle, 6'b110000);
    check_val("reset_stall_cnt", bus.StallCycles, 4'd0);
    check_val("reset_flush_cnt", bus.FlushCount, 4'd0);
    reset = 1'b0;

    for (int k = 0; k < 11; k++) begin
      step($sformatf("vec%0d", k), tbl[k].in, tbl[k].exp);
    end

    // Load-use releases after exactly one cycle once the bubble reaches EX.
    step("lu_stall", lu, 6'b000100);
    step("lu_release", mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
         6'b110000);

    // Mult/div with mflo in ID: stall cycles 0..LAT, done at LAT, go at LAT+1.
    step("md_c0", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0),
         6'b000110);
    for (int c = 1; c < LAT; c++) begin
      step($sformatf("md_c%0d", c),
           mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0), 6'b000110);
    end
    step("md_done", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0),
         6'b000111);
    step("md_proceed", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0),
         6'b110000);

    // Branch does not cancel a running op; reset at count 2 kills it silently.
    step("rst_start", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0),
         6'b110010);
    step("rst_cnt4_br", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1),
         6'b111110);
    step("rst_cnt3", idle, 6'b110010);
    reset = 1'b1;
    step("rst_cnt2", idle, 6'b110010);
    reset = 1'b0;
    step("rst_after", idle, 6'b110000);
    step("rst_no_done", idle, 6'b110000);

    // Performance counters from a clean reset.
    reset = 1'b1;
    step("perf_reset", idle, 6'b110000);
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step($sformatf("perf_lu%0d", n), lu, 6'b000100);
    end
    step("perf_jump", mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
         6'b111000);
    step("perf_branch", mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1),
         6'b111100);
`ifdef HAZARD_PERF_EN
    check_val("perf_stall_sat", bus.StallCycles, 4'd15);
    check_val("perf_flush_cnt", bus.FlushCount, 4'd2);
`else
    check_val("perf_stall_off", bus.StallCycles, 4'd0);
    check_val("perf_flush_off", bus.FlushCount, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
